// File: rtl/multi_cycle_cpu_io_if.sv
// Memory/I-O bus between the multi-cycle CPU (master) and memory, I/O and VRAM (slave).
interface multi_cycle_cpu_io_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic        mem_ready;
  logic        ifetch;
  logic        write;
  logic        io_rdn;
  logic        io_wrn;
  logic        rvram;
  logic        wvram;
  logic        torv;

  modport master (
    output mem_addr, mem_wdata, mem_req, ifetch, write, io_rdn, io_wrn, rvram, wvram, torv,
    input  mem_rdata, mem_ready
  );
  modport slave (
    input  mem_addr, mem_wdata, mem_req, ifetch, write, io_rdn, io_wrn, rvram, wvram, torv,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/multi_cycle_cpu_io.sv
// Multi-cycle MIPS-subset CPU (IF/ID/EX/MEM/WB) with a request/ready bus and
// address-tag decoded data-memory, I/O and VRAM strobes plus a display-mode flag.
module multi_cycle_cpu_io #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [2:0]  IO_TAG   = 3'b101,
  parameter logic [2:0]  VR_TAG   = 3'b110,
  parameter logic [3:0]  MODE_TAG = 4'h9
) (
  input  logic                  clk,
  input  logic                  clrn,
  multi_cycle_cpu_io_if.master  bus,
  output logic                  mode,
  output logic [2:0]            state,
  output logic [31:0]           pc
);
  typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;
  typedef enum logic [2:0] {K_NOP, K_ALU, K_LD, K_ST, K_JMP} kind_t;

  state_t      r_state, w_next;
  kind_t       w_kind;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_aluout, r_mdr;
  logic        r_mode;
  logic [31:0] r_rf [32];

  logic [5:0]  w_op, w_fn;
  logic [4:0]  w_rs, w_rt, w_rd, w_sh, w_dst, w_link_dst, w_wa;
  logic [31:0] w_sext, w_zext, w_br_tgt, w_j_tgt, w_res, w_pc_nx, w_wd;
  logic [2:0]  w_tag;
  logic        w_pc_ld, w_link, w_we;

  assign w_op     = r_ir[31:26];
  assign w_rs     = r_ir[25:21];
  assign w_rt     = r_ir[20:16];
  assign w_rd     = r_ir[15:11];
  assign w_sh     = r_ir[10:6];
  assign w_fn     = r_ir[5:0];
  assign w_sext   = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_zext   = {16'h0000, r_ir[15:0]};
  // r_pc already holds pc+4 of the executing instruction
  assign w_br_tgt = r_pc + (w_sext << 2);
  assign w_j_tgt  = {r_pc[31:28], r_ir[25:0], 2'b00};
  assign w_tag    = r_aluout[31:29];

  always_comb begin : decode
    w_kind     = K_NOP;
    w_res      = '0;
    w_dst      = w_rt;
    w_pc_ld    = 1'b0;
    w_pc_nx    = w_br_tgt;
    w_link     = 1'b0;
    w_link_dst = 5'd31;
    case (w_op)
      6'h00: begin
        w_dst  = w_rd;
        w_kind = K_ALU;
        case (w_fn)
          6'h00: w_res = r_b << w_sh;
          6'h02: w_res = r_b >> w_sh;
          6'h03: w_res = 32'($signed(r_b) >>> w_sh);
          6'h04: w_res = r_b << r_a[4:0];
          6'h06: w_res = r_b >> r_a[4:0];
          6'h07: w_res = 32'($signed(r_b) >>> r_a[4:0]);
          6'h08: begin w_kind = K_JMP; w_pc_ld = 1'b1; w_pc_nx = r_a; end
          6'h09: begin
            w_kind = K_JMP; w_pc_ld = 1'b1; w_pc_nx = r_a;
            w_link = 1'b1; w_link_dst = w_rd;
          end
          6'h20: w_res = r_a + r_b;
          6'h22: w_res = r_a - r_b;
          6'h24: w_res = r_a & r_b;
          6'h25: w_res = r_a | r_b;
          6'h26: w_res = r_a ^ r_b;
          6'h27: w_res = ~(r_a | r_b);
          6'h2A: w_res = {31'd0, $signed(r_a) < $signed(r_b)};
          6'h2B: w_res = {31'd0, r_a < r_b};
          default: w_kind = K_NOP;
        endcase
      end
      6'h02: begin w_kind = K_JMP; w_pc_ld = 1'b1; w_pc_nx = w_j_tgt; end
      6'h03: begin w_kind = K_JMP; w_pc_ld = 1'b1; w_pc_nx = w_j_tgt; w_link = 1'b1; end
      6'h04: begin w_kind = K_JMP; w_pc_ld = (r_a == r_b); end
      6'h05: begin w_kind = K_JMP; w_pc_ld = (r_a != r_b); end
      6'h08: begin w_kind = K_ALU; w_res = r_a + w_sext; end
      6'h0A: begin w_kind = K_ALU; w_res = {31'd0, $signed(r_a) < $signed(w_sext)}; end
      6'h0B: begin w_kind = K_ALU; w_res = {31'd0, r_a < w_sext}; end
      6'h0C: begin w_kind = K_ALU; w_res = r_a & w_zext; end
      6'h0D: begin w_kind = K_ALU; w_res = r_a | w_zext; end
      6'h0E: begin w_kind = K_ALU; w_res = r_a ^ w_zext; end
      6'h0F: begin w_kind = K_ALU; w_res = {r_ir[15:0], 16'h0000}; end
      6'h23: begin w_kind = K_LD;  w_res = r_a + w_sext; end
      6'h2B: begin w_kind = K_ST;  w_res = r_a + w_sext; end
      default: w_kind = K_NOP;
    endcase
  end

  // Bus outputs depend only on registered state, so they hold through any wait.
  always_comb begin : fsm
    w_next        = r_state;
    bus.mem_req   = 1'b0;
    bus.ifetch    = 1'b0;
    bus.mem_addr  = r_aluout;
    bus.mem_wdata = r_b;
    bus.write     = 1'b0;
    bus.io_rdn    = 1'b1;
    bus.io_wrn    = 1'b1;
    bus.rvram     = 1'b0;
    bus.wvram     = 1'b0;
    case (r_state)
      S_IF: begin
        bus.mem_req  = clrn;
        bus.ifetch   = clrn;
        bus.mem_addr = r_pc;
        if (bus.mem_ready) w_next = S_ID;
      end
      S_ID: w_next = S_EX;
      S_EX: begin
        case (w_kind)
          K_ALU:      w_next = S_WB;
          K_LD, K_ST: w_next = S_MEM;
          default:    w_next = S_IF;
        endcase
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.write   = (w_kind == K_ST) && (r_aluout[31:28] == 4'h0);
        bus.io_rdn  = !((w_kind == K_LD) && (w_tag == IO_TAG));
        bus.io_wrn  = !((w_kind == K_ST) && (w_tag == IO_TAG));
        bus.rvram   = (w_kind == K_LD) && (w_tag == VR_TAG);
        bus.wvram   = (w_kind == K_ST) && (w_tag == VR_TAG);
        if (bus.mem_ready) w_next = (w_kind == K_LD) ? S_WB : S_IF;
      end
      S_WB:    w_next = S_IF;
      default: w_next = S_IF;
    endcase
  end

  assign bus.torv = ~bus.mem_addr[28];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state  <= S_IF;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
      r_mode   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IF: if (bus.mem_ready) begin
          r_ir <= bus.mem_rdata;
          r_pc <= r_pc + 32'd4;
        end
        S_ID: begin
          r_a <= (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
          r_b <= (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];
        end
        S_EX: begin
          r_aluout <= w_res;
          if (w_pc_ld) r_pc <= w_pc_nx;
        end
        S_MEM: if (bus.mem_ready) begin
          r_mdr <= bus.mem_rdata;
          if (w_kind == K_ST && r_aluout[31:28] == MODE_TAG) r_mode <= ~r_mode;
        end
        default: ;
      endcase
    end
  end

  // Links write in EX, everything else in WB; $0 is never written.
  always_comb begin
    w_we = 1'b0;
    w_wa = w_dst;
    w_wd = r_aluout;
    if (r_state == S_EX && w_link) begin
      w_we = 1'b1;
      w_wa = w_link_dst;
      w_wd = r_pc;
    end else if (r_state == S_WB) begin
      w_we = 1'b1;
      if (w_kind == K_LD) w_wd = r_mdr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we && w_wa != 5'd0) r_rf[w_wa] <= w_wd;
  end

  assign mode  = r_mode;
  assign state = r_state;
  assign pc    = r_pc;
endmodule

// File: tb/tb_multi_cycle_cpu_io.sv
// Directed bench for multi_cycle_cpu_io: small programs in a bench-side ROM,
// register values observed through sw data on the bus.
module tb_multi_cycle_cpu_io;
  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        mode;
  logic [2:0]  state;
  logic [31:0] pc;
  multi_cycle_cpu_io_if bus();

  multi_cycle_cpu_io dut (
    .clk(clk), .clrn(clrn), .bus(bus), .mode(mode), .state(state), .pc(pc)
  );

  always #5 clk = ~clk;

  int          n_tests, n_fail, cyc, waits, wcnt;
  logic [31:0] load_val;
  logic [31:0] imem [64];

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] rr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] ji(input logic [5:0] op, input logic [25:0] a);
    return {op, a};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  endtask

  // One bus cycle: observe at the negedge, then answer for the coming posedge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.mem_req) begin
      if (bus.ifetch) begin
        bus.mem_rdata = imem[bus.mem_addr[7:2]];
        bus.mem_ready = 1'b1;
      end else begin
        bus.mem_rdata = load_val;
        if (wcnt < waits) begin bus.mem_ready = 1'b0; wcnt++; end
        else begin bus.mem_ready = 1'b1; wcnt = 0; end
      end
    end else begin
      bus.mem_ready = 1'b0;
    end
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    wcnt = 0; waits = 0; load_val = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1 clrn = 1'b1;
    cyc = 0;
  endtask

  task automatic run_to_state(input logic [2:0] s, input int max, output bit to);
    to = 1'b1;
    for (int i = 0; i < max; i++) begin
      step();
      if (state == s) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    bit to;
    clear_imem();
    clrn = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    #3;
    n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", state); end
    n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", pc); end
    n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", bus.mem_req); end
    n_tests++; if (mode !== 1'b0) begin n_fail++; $display("FAIL rst_mode: got %b want 0", mode); end
    n_tests++; if ({bus.io_rdn, bus.io_wrn, bus.write, bus.rvram, bus.wvram} !== 5'b11000) begin
      n_fail++; $display("FAIL rst_strobes: got %b want 11000", {bus.io_rdn, bus.io_wrn, bus.write, bus.rvram, bus.wvram});
    end
    do_reset();
    step();
    n_tests++; if (bus.mem_req !== 1'b1 || bus.ifetch !== 1'b1) begin
      n_fail++; $display("FAIL first_fetch_req: got req=%b ifetch=%b want 1 1", bus.mem_req, bus.ifetch);
    end
    n_tests++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL first_fetch_addr: got %h want 0", bus.mem_addr); end
    run_to_state(3'd1, 4, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL nop_reaches_id: got timeout want ID"); end
  endtask

  task automatic test_zero_wait();
    bit to;
    clear_imem();
    imem[0] = ri(6'h08, 0, 1, 16'd5);
    imem[1] = ri(6'h08, 0, 2, 16'hFFFD);
    imem[2] = rr(1, 2, 3, 0, 6'h20);
    imem[3] = ri(6'h2B, 0, 3, 16'h0010);
    do_reset();
    step(); step();
    n_tests++; if (state !== 3'd1 || bus.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL zw_id_idle: got state=%0d req=%b want 1 0", state, bus.mem_req);
    end
    run_to_state(3'd3, 40, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL zw_timeout: got timeout want MEM"); end
    n_tests++; if (cyc !== 16) begin n_fail++; $display("FAIL zw_cycle: got %0d want 16", cyc); end
    n_tests++; if (bus.write !== 1'b1 || bus.ifetch !== 1'b0) begin
      n_fail++; $display("FAIL zw_write: got write=%b ifetch=%b want 1 0", bus.write, bus.ifetch);
    end
    n_tests++; if (bus.mem_addr !== 32'h10) begin n_fail++; $display("FAIL zw_addr: got %h want 10", bus.mem_addr); end
    n_tests++; if (bus.mem_wdata !== 32'h2) begin n_fail++; $display("FAIL zw_wdata: got %h want 2", bus.mem_wdata); end
    n_tests++; if (bus.io_wrn !== 1'b1 || bus.wvram !== 1'b0) begin
      n_fail++; $display("FAIL zw_other_strobes: got io_wrn=%b wvram=%b want 1 0", bus.io_wrn, bus.wvram);
    end
    step();
    n_tests++; if (state !== 3'd0 || bus.mem_addr !== 32'h10) begin
      n_fail++; $display("FAIL zw_next_fetch: got state=%0d addr=%h want 0 10", state, bus.mem_addr);
    end
  endtask

  task automatic test_io_load();
    bit to;
    int lowcnt, bad, n;
    clear_imem();
    imem[0] = ri(6'h0F, 0, 5, 16'hA000);
    imem[1] = ri(6'h23, 5, 6, 16'h0004);
    imem[2] = ri(6'h2B, 0, 6, 16'h0020);
    do_reset();
    waits = 3;
    load_val = 32'hDEAD_BEEF;
    run_to_state(3'd3, 40, to);
    n_tests++; if (to || cyc !== 8) begin n_fail++; $display("FAIL io_mem_start: got cycle %0d (to=%b) want 8", cyc, to); end
    lowcnt = 0; bad = 0; n = 0;
    while (state == 3'd3 && n < 20) begin
      if (bus.io_rdn == 1'b0) lowcnt++;
      if (bus.mem_addr !== 32'hA000_0004 || bus.io_wrn !== 1'b1 || bus.write !== 1'b0 || bus.rvram !== 1'b0) bad++;
      step();
      n++;
    end
    n_tests++; if (lowcnt !== 4) begin n_fail++; $display("FAIL io_rdn_cycles: got %0d want 4", lowcnt); end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL io_addr_stable: got %0d bad cycles want 0", bad); end
    run_to_state(3'd0, 10, to);
    n_tests++; if (to || cyc !== 13) begin n_fail++; $display("FAIL io_lw_length: got next fetch cycle %0d want 13", cyc); end
    waits = 0;
    run_to_state(3'd3, 20, to);
    n_tests++; if (to || bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_addr !== 32'h20) begin
      n_fail++; $display("FAIL io_lw_data: got %h @%h want deadbeef @20", bus.mem_wdata, bus.mem_addr);
    end
  endtask

  task automatic test_slt();
    bit to;
    logic [31:0] exp_v [4];
    exp_v = '{32'd1, 32'd0, 32'd1, 32'd1};
    clear_imem();
    imem[0] = ri(6'h08, 0, 1, 16'hFFFF);
    imem[1] = ri(6'h08, 0, 2, 16'h0001);
    imem[2] = rr(1, 2, 3, 0, 6'h2A);
    imem[3] = rr(1, 2, 4, 0, 6'h2B);
    imem[4] = ri(6'h0A, 1, 5, 16'h0000);
    imem[5] = ri(6'h0B, 2, 6, 16'hFFFF);
    for (int k = 0; k < 4; k++) imem[6+k] = ri(6'h2B, 0, 5'(3+k), 16'(4*k));
    do_reset();
    for (int k = 0; k < 4; k++) begin
      run_to_state(3'd3, 60, to);
      n_tests++; if (to || bus.mem_addr !== 32'(4*k) || bus.mem_wdata !== exp_v[k]) begin
        n_fail++; $display("FAIL slt_%0d: got %h @%h want %h @%h", k, bus.mem_wdata, bus.mem_addr, exp_v[k], 4*k);
      end
    end
  endtask

  task automatic test_alu();
    bit to;
    logic [31:0] exp_v [7];
    logic [4:0]  sreg [7];
    exp_v = '{32'hF800_0000, 32'h0800_0000, 32'h0000_FFFF, 32'hFFFF_0001, 32'h00FF_FF00, 32'h0000_8001, 32'h0};
    sreg  = '{5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd9, 5'd0};
    clear_imem();
    imem[0]  = ri(6'h0F, 0, 1, 16'h8000);
    imem[1]  = rr(0, 1, 2, 4, 6'h03);
    imem[2]  = rr(0, 1, 3, 4, 6'h02);
    imem[3]  = ri(6'h0E, 0, 4, 16'hFFFF);
    imem[4]  = rr(0, 0, 5, 0, 6'h27);
    imem[5]  = rr(0, 4, 6, 0, 6'h22);
    imem[6]  = ri(6'h0D, 0, 8, 16'h0008);
    imem[7]  = rr(8, 4, 7, 0, 6'h04);
    imem[8]  = ri(6'h0C, 5, 9, 16'h8001);
    imem[9]  = 32'hFC09_1234;
    imem[10] = rr(5, 5, 9, 0, 6'h3F);
    imem[11] = ri(6'h08, 0, 0, 16'h0007);
    for (int k = 0; k < 7; k++) imem[12+k] = ri(6'h2B, 0, sreg[k], 16'(4*k));
    do_reset();
    for (int k = 0; k < 7; k++) begin
      run_to_state(3'd3, 80, to);
      n_tests++; if (to || bus.mem_addr !== 32'(4*k) || bus.mem_wdata !== exp_v[k]) begin
        n_fail++; $display("FAIL alu_%0d: got %h @%h want %h @%h", k, bus.mem_wdata, bus.mem_addr, exp_v[k], 4*k);
      end
    end
  endtask

  task automatic test_mode();
    bit to;
    clear_imem();
    imem[0] = ri(6'h0F, 0, 1, 16'h9000);
    imem[1] = ri(6'h0F, 0, 2, 16'hC000);
    imem[2] = ri(6'h2B, 1, 0, 16'h0000);
    imem[3] = ri(6'h2B, 1, 0, 16'h0000);
    imem[4] = ri(6'h2B, 2, 0, 16'h0000);
    do_reset();
    run_to_state(3'd3, 40, to);
    n_tests++; if (to || mode !== 1'b0 || bus.mem_addr !== 32'h9000_0000 || bus.write !== 1'b0) begin
      n_fail++; $display("FAIL mode_st1: got mode=%b addr=%h write=%b want 0 90000000 0", mode, bus.mem_addr, bus.write);
    end
    step();
    n_tests++; if (mode !== 1'b1) begin n_fail++; $display("FAIL mode_toggle1: got %b want 1", mode); end
    run_to_state(3'd3, 20, to);
    step();
    n_tests++; if (to || mode !== 1'b0) begin n_fail++; $display("FAIL mode_toggle2: got %b want 0", mode); end
    run_to_state(3'd3, 20, to);
    n_tests++; if (to || bus.wvram !== 1'b1 || bus.torv !== 1'b1 || bus.write !== 1'b0) begin
      n_fail++; $display("FAIL vram_store: got wvram=%b torv=%b write=%b want 1 1 0", bus.wvram, bus.torv, bus.write);
    end
    step();
    n_tests++; if (mode !== 1'b0) begin n_fail++; $display("FAIL mode_vram_unchanged: got %b want 0", mode); end
  endtask

  task automatic test_branch();
    bit to;
    bit found;
    clear_imem();
    imem[0]  = ji(6'h02, 26'h8);
    imem[7]  = ji(6'h02, 26'h10);
    imem[8]  = ri(6'h04, 0, 0, 16'hFFFE);
    imem[16] = ji(6'h03, 26'h18);
    imem[24] = ri(6'h05, 31, 0, 16'd2);
    imem[25] = ri(6'h2B, 0, 0, 16'h0008);
    imem[27] = ri(6'h2B, 0, 31, 16'h0000);
    imem[28] = ri(6'h08, 0, 8, 16'h0080);
    imem[29] = rr(8, 0, 0, 0, 6'h08);
    imem[30] = ri(6'h2B, 0, 0, 16'h000C);
    imem[32] = ri(6'h2B, 0, 8, 16'h0004);
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (state == 3'd0 && bus.mem_addr == 32'h20) found = 1'b1;
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL j_to_20: got no fetch at 20 want fetch at 20"); end
    run_to_state(3'd1, 10, to);
    run_to_state(3'd0, 10, to);
    n_tests++; if (to || bus.mem_addr !== 32'h1C) begin n_fail++; $display("FAIL beq_target: got %h want 1c", bus.mem_addr); end
    run_to_state(3'd3, 60, to);
    n_tests++; if (to || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h44) begin
      n_fail++; $display("FAIL jal_link: got %h @%h want 44 @0", bus.mem_wdata, bus.mem_addr);
    end
    run_to_state(3'd3, 60, to);
    n_tests++; if (to || bus.mem_addr !== 32'h4 || bus.mem_wdata !== 32'h80) begin
      n_fail++; $display("FAIL jr_target: got %h @%h want 80 @4", bus.mem_wdata, bus.mem_addr);
    end
  endtask

  task automatic test_reset_midwait();
    bit to;
    clear_imem();
    imem[0] = ri(6'h0F, 0, 1, 16'h9000);
    imem[1] = ri(6'h2B, 1, 0, 16'h0000);
    imem[2] = ri(6'h0F, 0, 2, 16'hA000);
    imem[3] = ri(6'h23, 2, 3, 16'h0000);
    do_reset();
    run_to_state(3'd3, 40, to);
    step();
    n_tests++; if (to || mode !== 1'b1) begin n_fail++; $display("FAIL mw_mode_set: got %b want 1", mode); end
    waits = 10;
    run_to_state(3'd3, 40, to);
    step(); step();
    n_tests++; if (to || bus.mem_req !== 1'b1 || bus.io_rdn !== 1'b0) begin
      n_fail++; $display("FAIL mw_waiting: got req=%b io_rdn=%b want 1 0", bus.mem_req, bus.io_rdn);
    end
    #2 clrn = 1'b0;
    #1;
    n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL mw_req_drop: got %b want 0", bus.mem_req); end
    n_tests++; if (state !== 3'd0 || pc !== 32'h0) begin
      n_fail++; $display("FAIL mw_state_pc: got state=%0d pc=%h want 0 0", state, pc);
    end
    n_tests++; if (mode !== 1'b0 || bus.io_rdn !== 1'b1) begin
      n_fail++; $display("FAIL mw_mode_strobe: got mode=%b io_rdn=%b want 0 1", mode, bus.io_rdn);
    end
    @(posedge clk);
    #1 clrn = 1'b1;
    cyc = 0; wcnt = 0; waits = 0;
    step();
    n_tests++; if (bus.mem_addr !== 32'h0 || bus.ifetch !== 1'b1 || bus.mem_req !== 1'b1) begin
      n_fail++; $display("FAIL mw_refetch: got addr=%h ifetch=%b req=%b want 0 1 1", bus.mem_addr, bus.ifetch, bus.mem_req);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    test_reset();
    test_zero_wait();
    test_io_load();
    test_slt();
    test_alu();
    test_mode();
    test_branch();
    test_reset_midwait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1);
  end
endmodule
